// File: rtl/student_fir_sched.sv
// Sample-rate scheduler: one FIR compute per codec sample, timeout guard, coefficient-bank swaps between samples.
// Optional sticky event interrupt when FIR_SCHED_IRQ_EN is defined; otherwise irq_o is tied low.
module student_fir_sched #(
  parameter int unsigned DATA_SIZE         = 16,
  parameter int unsigned DATA_SIZE_FIR_OUT = 32,
  parameter int unsigned TIMEOUT_CYCLES    = 2048,
  parameter int unsigned CNT_WIDTH         = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         sample_valid_i,
  input  logic [DATA_SIZE-1:0]         sample_i,
  output logic                         fir_start_o,
  output logic [DATA_SIZE-1:0]         fir_sample_o,
  input  logic                         fir_done_i,
  input  logic [DATA_SIZE_FIR_OUT-1:0] fir_y_i,
  output logic                         out_valid_o,
  output logic [DATA_SIZE_FIR_OUT-1:0] out_data_o,
  input  logic                         swap_req_i,
  output logic                         bank_sel_o,
  output logic                         swap_ack_o,
  output logic                         busy_o,
  output logic [CNT_WIDTH-1:0]         overrun_cnt_o,
  output logic [CNT_WIDTH-1:0]         timeout_cnt_o,
  input  logic                         irq_clr_i,
  output logic                         irq_o
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_OUT,
    ST_SWAP
  } state_e;

  state_e                       state_q, state_d;
  logic [TMR_W-1:0]             timer_q, timer_d;
  logic                         swap_pending_q, swap_pending_d;
  logic                         fir_start_q, fir_start_d;
  logic [DATA_SIZE-1:0]         fir_sample_q, fir_sample_d;
  logic                         out_valid_q, out_valid_d;
  logic [DATA_SIZE_FIR_OUT-1:0] out_data_q, out_data_d;
  logic                         bank_sel_q, bank_sel_d;
  logic                         swap_ack_q, swap_ack_d;
  logic                         busy_q, busy_d;
  logic [CNT_WIDTH-1:0]         overrun_cnt_q, overrun_cnt_d;
  logic [CNT_WIDTH-1:0]         timeout_cnt_q, timeout_cnt_d;
  logic                         irq_q, irq_d;
  logic                         overrun_evt;
  logic                         timeout_evt;

`ifndef FIR_SCHED_IRQ_EN
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr_i;
`endif

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      swap_pending_q <= 1'b0;
      fir_start_q    <= 1'b0;
      fir_sample_q   <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      bank_sel_q     <= 1'b0;
      swap_ack_q     <= 1'b0;
      busy_q         <= 1'b0;
      overrun_cnt_q  <= '0;
      timeout_cnt_q  <= '0;
      irq_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      swap_pending_q <= swap_pending_d;
      fir_start_q    <= fir_start_d;
      fir_sample_q   <= fir_sample_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      bank_sel_q     <= bank_sel_d;
      swap_ack_q     <= swap_ack_d;
      busy_q         <= busy_d;
      overrun_cnt_q  <= overrun_cnt_d;
      timeout_cnt_q  <= timeout_cnt_d;
      irq_q          <= irq_d;
    end
  end

  // Next-state, event detection and next output values
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    swap_pending_d = swap_pending_q | swap_req_i;
    fir_sample_d   = fir_sample_q;
    out_data_d     = out_data_q;
    bank_sel_d     = bank_sel_q;
    overrun_cnt_d  = overrun_cnt_q;
    timeout_cnt_d  = timeout_cnt_q;
    irq_d          = irq_q;
    timeout_evt    = 1'b0;
    overrun_evt    = sample_valid_i && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (sample_valid_i) begin
          state_d      = ST_START;
          fir_sample_d = sample_i;
        end else if (swap_pending_q) begin
          state_d    = ST_SWAP;
          bank_sel_d = ~bank_sel_q;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
        timer_d = '0;
      end
      ST_WAIT: begin
        // A done arriving on the last timer cycle still counts as a completed compute
        if (fir_done_i) begin
          state_d    = ST_OUT;
          out_data_d = fir_y_i;
        end else if (timer_q == TMR_LAST) begin
          state_d     = ST_OUT;
          timeout_evt = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_OUT: begin
        state_d = ST_IDLE;
      end
      ST_SWAP: begin
        state_d        = ST_IDLE;
        swap_pending_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    fir_start_d = (state_d == ST_START);
    out_valid_d = (state_d == ST_OUT);
    swap_ack_d  = (state_d == ST_SWAP);
    busy_d      = (state_d != ST_IDLE);

    if (overrun_evt && (overrun_cnt_q != CNT_MAX)) begin
      overrun_cnt_d = overrun_cnt_q + CNT_WIDTH'(1);
    end
    if (timeout_evt && (timeout_cnt_q != CNT_MAX)) begin
      timeout_cnt_d = timeout_cnt_q + CNT_WIDTH'(1);
    end

`ifdef FIR_SCHED_IRQ_EN
    if (overrun_evt || timeout_evt) begin
      irq_d = 1'b1;
    end else if (irq_clr_i) begin
      irq_d = 1'b0;
    end
`else
    irq_d = 1'b0;
`endif
  end

  assign fir_start_o   = fir_start_q;
  assign fir_sample_o  = fir_sample_q;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign bank_sel_o    = bank_sel_q;
  assign swap_ack_o    = swap_ack_q;
  assign busy_o        = busy_q;
  assign overrun_cnt_o = overrun_cnt_q;
  assign timeout_cnt_o = timeout_cnt_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_student_fir_sched.sv
// Bench for student_fir_sched: two instances (default parameters, and TIMEOUT_CYCLES=8 / CNT_WIDTH=2)
// driven by shared inputs, checked against a cycle model plus hand-derived vectors.
module tb_student_fir_sched;

`ifdef FIR_SCHED_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  localparam int P_IDLE  = 0;
  localparam int P_START = 1;
  localparam int P_WAIT  = 2;
  localparam int P_OUT   = 3;
  localparam int P_SWAP  = 4;

  typedef struct packed {
    logic        start;
    logic [15:0] fsamp;
    logic        valid;
    logic [31:0] odata;
    logic        bank;
    logic        ack;
    logic        busy;
    logic [15:0] ovr;
    logic [15:0] tmo;
    logic        irq;
  } obs_t;

  typedef struct {
    int          phase;
    int unsigned age;
    bit          pending;
    obs_t        o;
  } mdl_t;

  typedef struct {
    logic        sv;
    logic [15:0] s;
    logic        done;
    logic [31:0] y;
    logic        swreq;
    logic        e_start;
    logic        e_valid;
    logic        e_busy;
    logic        e_bank;
    logic        e_ack;
    logic [15:0] e_fsamp;
    logic [31:0] e_odata;
  } vec_t;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_i, sample_valid_i, fir_done_i, swap_req_i, irq_clr_i;
  logic [15:0] sample_i;
  logic [31:0] fir_y_i;

  logic        start_a, valid_a, bank_a, ack_a, busy_a, irq_a;
  logic [15:0] fsamp_a, ovr_a, tmo_a;
  logic [31:0] odata_a;
  logic        start_b, valid_b, bank_b, ack_b, busy_b, irq_b;
  logic [15:0] fsamp_b;
  logic [1:0]  ovr_b, tmo_b;
  logic [31:0] odata_b;

  student_fir_sched dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .sample_valid_i(sample_valid_i), .sample_i(sample_i),
    .fir_start_o(start_a), .fir_sample_o(fsamp_a), .fir_done_i(fir_done_i), .fir_y_i(fir_y_i),
    .out_valid_o(valid_a), .out_data_o(odata_a), .swap_req_i(swap_req_i), .bank_sel_o(bank_a),
    .swap_ack_o(ack_a), .busy_o(busy_a), .overrun_cnt_o(ovr_a), .timeout_cnt_o(tmo_a),
    .irq_clr_i(irq_clr_i), .irq_o(irq_a)
  );

  student_fir_sched #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(2)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .sample_valid_i(sample_valid_i), .sample_i(sample_i),
    .fir_start_o(start_b), .fir_sample_o(fsamp_b), .fir_done_i(fir_done_i), .fir_y_i(fir_y_i),
    .out_valid_o(valid_b), .out_data_o(odata_b), .swap_req_i(swap_req_i), .bank_sel_o(bank_b),
    .swap_ack_o(ack_b), .busy_o(busy_b), .overrun_cnt_o(ovr_b), .timeout_cnt_o(tmo_b),
    .irq_clr_i(irq_clr_i), .irq_o(irq_b)
  );

  obs_t act_a, act_b;
  assign act_a = {start_a, fsamp_a, valid_a, odata_a, bank_a, ack_a, busy_a, ovr_a, tmo_a, irq_a};
  assign act_b = {start_b, fsamp_b, valid_b, odata_b, bank_b, ack_b, busy_b,
                  14'd0, ovr_b, 14'd0, tmo_b, irq_b};

  int   n_checks = 0;
  int   n_err    = 0;
  mdl_t mdl_a, mdl_b;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_obs(input string who, input obs_t a, input obs_t e);
    chk({who, ".fir_start"},   64'(a.start), 64'(e.start));
    chk({who, ".fir_sample"},  64'(a.fsamp), 64'(e.fsamp));
    chk({who, ".out_valid"},   64'(a.valid), 64'(e.valid));
    chk({who, ".out_data"},    64'(a.odata), 64'(e.odata));
    chk({who, ".bank_sel"},    64'(a.bank),  64'(e.bank));
    chk({who, ".swap_ack"},    64'(a.ack),   64'(e.ack));
    chk({who, ".busy"},        64'(a.busy),  64'(e.busy));
    chk({who, ".overrun_cnt"}, 64'(a.ovr),   64'(e.ovr));
    chk({who, ".timeout_cnt"}, 64'(a.tmo),   64'(e.tmo));
    chk({who, ".irq"},         64'(a.irq),   64'(e.irq));
  endtask

  // Behavioural model: what the scheduler must show one clock after seeing these inputs
  function automatic mdl_t model_next(input mdl_t m, input int unsigned to_cycles,
                                      input int unsigned cnt_max, input logic rst,
                                      input logic sv, input logic [15:0] s, input logic done,
                                      input logic [31:0] y, input logic swreq, input logic clr);
    mdl_t n;
    bit   ovf, tmo;
    n = m;
    if (rst) begin
      n.phase   = P_IDLE;
      n.age     = 0;
      n.pending = 1'b0;
      n.o       = '0;
    end else begin
      ovf       = sv && (m.phase != P_IDLE);
      tmo       = (m.phase == P_WAIT) && !done && (m.age == to_cycles - 1);
      n.pending = (m.phase == P_SWAP) ? 1'b0 : (m.pending | swreq);
      case (m.phase)
        P_IDLE:
          if (sv) begin
            n.phase   = P_START;
            n.o.fsamp = s;
          end else if (m.pending) begin
            n.phase  = P_SWAP;
            n.o.bank = !m.o.bank;
          end
        P_START: begin
          n.phase = P_WAIT;
          n.age   = 0;
        end
        P_WAIT:
          if (done) begin
            n.phase   = P_OUT;
            n.o.odata = y;
          end else if (tmo) begin
            n.phase = P_OUT;
          end else begin
            n.age = m.age + 1;
          end
        default: n.phase = P_IDLE;
      endcase
      n.o.start = (n.phase == P_START);
      n.o.valid = (n.phase == P_OUT);
      n.o.ack   = (n.phase == P_SWAP);
      n.o.busy  = (n.phase != P_IDLE);
      if (ovf && (32'(m.o.ovr) < cnt_max)) n.o.ovr = m.o.ovr + 16'd1;
      if (tmo && (32'(m.o.tmo) < cnt_max)) n.o.tmo = m.o.tmo + 16'd1;
      if (IRQ_EN) begin
        if (ovf || tmo) n.o.irq = 1'b1;
        else if (clr)   n.o.irq = 1'b0;
      end else begin
        n.o.irq = 1'b0;
      end
    end
    return n;
  endfunction

  task automatic step(input logic rst, input logic sv, input logic [15:0] s, input logic done,
                      input logic [31:0] y, input logic swreq, input logic clr);
    rst_i          = rst;
    sample_valid_i = sv;
    sample_i       = s;
    fir_done_i     = done;
    fir_y_i        = y;
    swap_req_i     = swreq;
    irq_clr_i      = clr;
    @(posedge clk_i);
    mdl_a = model_next(mdl_a, 2048, 65535, rst, sv, s, done, y, swreq, clr);
    mdl_b = model_next(mdl_b, 8, 3, rst, sv, s, done, y, swreq, clr);
    #1;
    chk_obs("A", act_a, mdl_a.o);
    chk_obs("B", act_b, mdl_b.o);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic sample(input logic [15:0] s);
    step(1'b0, 1'b1, s, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int   k;
    bit   got;
    obs_t zero;
    zero = '0;

    // Main transaction: sample 0x1234, done 10 cycles after start, two swap pulses during WAIT
    tbl[0] = '{1'b1, 16'h1234, 1'b0, 32'h0, 1'b0,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 32'h0};
    for (int i = 1; i <= 10; i++) begin
      tbl[i] = '{1'b0, 16'h0, 1'b0, 32'h0, (i == 3 || i == 6),
                 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 32'h0};
    end
    tbl[11] = '{1'b0, 16'h0, 1'b1, 32'h0000_ABCD, 1'b0,
                1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 32'h0000_ABCD};
    tbl[12] = '{1'b0, 16'h0, 1'b0, 32'h0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 32'h0000_ABCD};
    tbl[13] = '{1'b0, 16'h0, 1'b0, 32'h0, 1'b0,
                1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 32'h0000_ABCD};
    tbl[14] = '{1'b0, 16'h0, 1'b0, 32'h0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 32'h0000_ABCD};
    tbl[15] = '{1'b1, 16'h0BEE, 1'b0, 32'h0, 1'b0,
                1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0BEE, 32'h0000_ABCD};

    do_reset();
    do_reset();
    chk_obs("reset.A", act_a, zero);
    chk_obs("reset.B", act_b, zero);

    for (int i = 0; i < 16; i++) begin
      step(1'b0, tbl[i].sv, tbl[i].s, tbl[i].done, tbl[i].y, tbl[i].swreq, 1'b0);
      chk($sformatf("tbl%0d.fir_start", i),  64'(start_a), 64'(tbl[i].e_start));
      chk($sformatf("tbl%0d.out_valid", i),  64'(valid_a), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d.busy", i),       64'(busy_a),  64'(tbl[i].e_busy));
      chk($sformatf("tbl%0d.bank_sel", i),   64'(bank_a),  64'(tbl[i].e_bank));
      chk($sformatf("tbl%0d.swap_ack", i),   64'(ack_a),   64'(tbl[i].e_ack));
      chk($sformatf("tbl%0d.fir_sample", i), 64'(fsamp_a), 64'(tbl[i].e_fsamp));
      chk($sformatf("tbl%0d.out_data", i),   64'(odata_a), 64'(tbl[i].e_odata));
    end

    // Timeout on the 8-cycle instance after a completed compute with y=0x55
    do_reset();
    sample(16'h0011);
    idle();
    step(1'b0, 1'b0, 16'h0, 1'b1, 32'h55, 1'b0, 1'b0);
    idle();
    sample(16'h0022);
    k   = 0;
    got = 1'b0;
    while (k < 20 && !got) begin
      idle();
      k++;
      if (valid_b) got = 1'b1;
    end
    chk("tmo.latency",  64'(k),       64'(9));
    chk("tmo.out_data", 64'(odata_b), 64'(32'h55));
    chk("tmo.count",    64'(tmo_b),   64'(1));
    chk("tmo.irq",      64'(irq_b),   64'(IRQ_EN));
    chk("tmo.A_busy",   64'(busy_a),  64'(1));
    chk("tmo.A_count",  64'(tmo_a),   64'(0));
    step(1'b0, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("tmo.irq_clr",  64'(irq_b),   64'(0));

    // Overruns while busy: 3 then 5 drops, 2-bit counter saturates
    do_reset();
    sample(16'h0AAA);
    for (int i = 0; i < 3; i++) sample(16'(16'hF000 + i));
    chk("ovr3.A_count",  64'(ovr_a),   64'(3));
    chk("ovr3.B_count",  64'(ovr_b),   64'(3));
    chk("ovr3.A_sample", 64'(fsamp_a), 64'(16'h0AAA));
    chk("ovr3.B_sample", 64'(fsamp_b), 64'(16'h0AAA));
    sample(16'hF100);
    sample(16'hF101);
    chk("ovr5.A_count",  64'(ovr_a),   64'(5));
    chk("ovr5.B_count",  64'(ovr_b),   64'(3));

    // Pending swap loses to a simultaneous sample; done coinciding with timeout wins
    do_reset();
    step(1'b0, 1'b0, 16'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    sample(16'h0077);
    chk("prio.start", 64'(start_a), 64'(1));
    chk("prio.ack",   64'(ack_a),   64'(0));
    chk("prio.bank",  64'(bank_a),  64'(0));
    for (int i = 0; i < 8; i++) idle();
    step(1'b0, 1'b0, 16'h0, 1'b1, 32'hCAFE, 1'b0, 1'b0);
    chk("both.B_valid", 64'(valid_b), 64'(1));
    chk("both.B_data",  64'(odata_b), 64'(32'hCAFE));
    chk("both.B_tmo",   64'(tmo_b),   64'(0));
    chk("both.A_data",  64'(odata_a), 64'(32'hCAFE));
    idle();
    idle();
    chk("swap.A_ack",  64'(ack_a),  64'(1));
    chk("swap.A_bank", 64'(bank_a), 64'(1));
    chk("swap.B_ack",  64'(ack_b),  64'(1));
    chk("swap.B_bank", 64'(bank_b), 64'(1));
    step(1'b0, 1'b0, 16'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    idle();
    chk("lost.A_ack",  64'(ack_a),  64'(0));
    chk("lost.A_busy", 64'(busy_a), 64'(0));
    chk("lost.A_bank", 64'(bank_a), 64'(1));

    // Reset in WAIT abandons the compute; the late done is ignored
    sample(16'h0099);
    sample(16'h0001);
    chk("rstw.pre_ovr", 64'(ovr_a), 64'(1));
    do_reset();
    chk_obs("rstw.A", act_a, zero);
    chk_obs("rstw.B", act_b, zero);
    step(1'b0, 1'b0, 16'h0, 1'b1, 32'h1111, 1'b0, 1'b0);
    chk("rstw.valid", 64'(valid_a), 64'(0));
    chk("rstw.busy",  64'(busy_a),  64'(0));
    chk("rstw.data",  64'(odata_a), 64'(0));

    // Randomised traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 5) == 0), 16'($urandom),
           ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
